// File: rtl/delay_line_arbiter.sv
// delay_line_arbiter
// Round-robin arbiter that shares one variable-tap delay line among NREQ
// requesters. Each granted byte is dropped straight into the slot that will
// reach the output after exactly its requested delay. A request is only
// eligible when that slot is still free, so two items can never exit together.
// Slot 0 drives the registered outputs directly.
//
// Optional build macro: DLA_STATS_EN adds saturating grant/conflict counters
// (stat_grants, stat_conflicts). Without it those ports do not exist.
module delay_line_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ*2-1:0]       req_dly,
    output logic [NREQ-1:0]         gnt,
`ifdef DLA_STATS_EN
    output logic [15:0]             stat_grants,
    output logic [15:0]             stat_conflicts,
`endif
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [2:0]              out_id
);

    // Largest delay as a 2-bit value, used to clamp out-of-range requests.
    localparam logic [1:0] DMAX = 2'(DEPTH);

    // ------------------------------------------------------------------
    // Slot pipeline state: s[0] is the exit slot, s[DEPTH] the entry slot.
    // ------------------------------------------------------------------
    logic             slot_valid_q [0:DEPTH];
    logic             slot_valid_d [0:DEPTH];
    logic [2:0]       slot_id_q    [0:DEPTH];
    logic [2:0]       slot_id_d    [0:DEPTH];
    logic [WIDTH-1:0] slot_data_q  [0:DEPTH];
    logic [WIDTH-1:0] slot_data_d  [0:DEPTH];

    // Round-robin pointer: the requester searched first this cycle.
    logic [2:0]       ptr_q;
    logic [2:0]       ptr_d;

    // Arbitration results.
    logic [DEPTH:0]   land_free;
    logic [1:0]       dly_eff [NREQ];
    logic [NREQ-1:0]  elig;
    logic             grant_hit;
    logic [2:0]       grant_idx;
    logic [WIDTH-1:0] g_data;
    logic [1:0]       g_dly;

    // ------------------------------------------------------------------
    // Slot d is free after this edge's shift when s[d+1] is empty now.
    // The entry slot always receives an empty value, so it is always free.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi <= DEPTH; gi++) begin : g_land
            if (gi == DEPTH) begin : g_top
                assign land_free[gi] = 1'b1;
            end else begin : g_mid
                assign land_free[gi] = ~slot_valid_q[gi+1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-requester delay clamp and eligibility.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            assign dly_eff[gi] = (req_dly[gi*2 +: 2] > DMAX) ? DMAX : req_dly[gi*2 +: 2];
            assign elig[gi]    = req[gi] & land_free[dly_eff[gi]];
        end
    endgenerate

    // Round-robin pick: first eligible at or above the pointer, then wrap.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        g_data    = '0;
        g_dly     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_hit && elig[k] && (k >= int'(ptr_q))) begin
                grant_hit = 1'b1;
                grant_idx = 3'(k);
                g_data    = req_data[k*WIDTH +: WIDTH];
                g_dly     = dly_eff[k];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_hit && elig[k] && (k < int'(ptr_q))) begin
                grant_hit = 1'b1;
                grant_idx = 3'(k);
                g_data    = req_data[k*WIDTH +: WIDTH];
                g_dly     = dly_eff[k];
            end
        end
    end

    // One-hot grant, suppressed while reset is asserted.
    always_comb begin
        gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            gnt[k] = reset && grant_hit && (grant_idx == 3'(k));
        end
    end

    // Pointer advances past the winner; holds when nobody is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_hit) begin
            ptr_d = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    // Shift every slot one step toward the exit, then drop the winner into
    // its landing slot (eligibility guarantees that slot is empty).
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            slot_valid_d[j] = slot_valid_q[j+1];
            slot_id_d[j]    = slot_id_q[j+1];
            slot_data_d[j]  = slot_data_q[j+1];
        end
        slot_valid_d[DEPTH] = 1'b0;
        slot_id_d[DEPTH]    = '0;
        slot_data_d[DEPTH]  = '0;
        for (int j = 0; j <= DEPTH; j++) begin
            if (grant_hit && (g_dly == 2'(j))) begin
                slot_valid_d[j] = 1'b1;
                slot_id_d[j]    = grant_idx;
                slot_data_d[j]  = g_data;
            end
        end
    end

    // Slot pipeline and pointer registers; reset discards all in-flight items.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j <= DEPTH; j++) begin
                slot_valid_q[j] <= 1'b0;
                slot_id_q[j]    <= '0;
                slot_data_q[j]  <= '0;
            end
            ptr_q <= '0;
        end else begin
            for (int j = 0; j <= DEPTH; j++) begin
                slot_valid_q[j] <= slot_valid_d[j];
                slot_id_q[j]    <= slot_id_d[j];
                slot_data_q[j]  <= slot_data_d[j];
            end
            ptr_q <= ptr_d;
        end
    end

    // The exit slot is the output register.
    assign out_valid = slot_valid_q[0];
    assign out_data  = slot_data_q[0];
    assign out_id    = slot_id_q[0];

`ifdef DLA_STATS_EN
    // ------------------------------------------------------------------
    // Saturating activity counters.
    // ------------------------------------------------------------------
    logic [15:0] stat_grants_q;
    logic [15:0] stat_grants_d;
    logic [15:0] stat_conflicts_q;
    logic [15:0] stat_conflicts_d;

    // A conflict is a cycle with requests pending but none of them eligible.
    always_comb begin
        stat_grants_d    = stat_grants_q;
        stat_conflicts_d = stat_conflicts_q;
        if (grant_hit && (stat_grants_q != 16'hFFFF)) begin
            stat_grants_d = stat_grants_q + 16'd1;
        end
        if ((|req) && !grant_hit && (stat_conflicts_q != 16'hFFFF)) begin
            stat_conflicts_d = stat_conflicts_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_grants_q    <= '0;
            stat_conflicts_q <= '0;
        end else begin
            stat_grants_q    <= stat_grants_d;
            stat_conflicts_q <= stat_conflicts_d;
        end
    end

    assign stat_grants    = stat_grants_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Testbench for delay_line_arbiter: directed scenarios with hand-computed
// expectations, then randomized traffic. A reservation-table model (one entry
// per future exit cycle) predicts grants and outputs and is compared against
// the DUT on every cycle.
module tb_delay_line_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [7:0]  req_dly = '0;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_id;
`ifdef DLA_STATS_EN
    logic [15:0] stat_grants;
    logic [15:0] stat_conflicts;
`endif

    delay_line_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .req_dly       (req_dly),
        .gnt           (gnt),
`ifdef DLA_STATS_EN
        .stat_grants   (stat_grants),
        .stat_conflicts(stat_conflicts),
`endif
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_id        (out_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: reservation table indexed by absolute exit cycle.
    // An item accepted in cycle c with delay d exits in cycle c+d+1, and a
    // request is eligible only if that exit cycle is not yet reserved.
    // ------------------------------------------------------------------
    logic       res_v    [8] = '{default: 1'b0};
    logic [2:0] res_id   [8] = '{default: 3'd0};
    logic [7:0] res_data [8] = '{default: 8'd0};
    int         ptr_m    = 0;
    int         cyc      = 0;
    int         m_grants = 0;
    int         m_conf   = 0;
    logic [3:0] mdl_gnt  = '0;

    always @(negedge clk) begin : model_cmp
        int         win;
        logic [1:0] kk;
        logic [1:0] dd;
        logic [2:0] ix;
        logic [2:0] slot;
        logic [3:0] exp_gnt;
        win = -1;
        dd  = '0;
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                kk = 2'((ptr_m + i) % NREQ);
                dd = req_dly[kk*2 +: 2];
                ix = 3'(cyc + int'(dd) + 1);
                if (win < 0 && req[kk] && !res_v[ix]) win = int'(kk);
            end
        end
        exp_gnt = (win >= 0) ? 4'(1 << win) : 4'd0;
        check("gnt", 32'(gnt), 32'(exp_gnt));

        slot = 3'(cyc);
        check("out_valid", 32'(out_valid), 32'(res_v[slot]));
        if (res_v[slot]) begin
            check("out_data", 32'(out_data), 32'(res_data[slot]));
            check("out_id", 32'(out_id), 32'(res_id[slot]));
        end
`ifdef DLA_STATS_EN
        check("stat_grants", 32'(stat_grants), 32'(m_grants));
        check("stat_conflicts", 32'(stat_conflicts), 32'(m_conf));
`endif

        res_v[slot] = 1'b0;
        if (!reset) begin
            for (int j = 0; j < 8; j++) res_v[j] = 1'b0;
            ptr_m    = 0;
            m_grants = 0;
            m_conf   = 0;
        end else if (win >= 0) begin
            kk = 2'(win);
            dd = req_dly[kk*2 +: 2];
            ix = 3'(cyc + int'(dd) + 1);
            res_v[ix]    = 1'b1;
            res_id[ix]   = 3'(win);
            res_data[ix] = req_data[kk*8 +: 8];
            ptr_m        = (win + 1) % NREQ;
            if (m_grants < 65535) m_grants++;
        end else if (|req) begin
            if (m_conf < 65535) m_conf++;
        end
        mdl_gnt = exp_gnt;
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] data, input logic [1:0] dly);
        req[i]             = 1'b1;
        req_data[i*8 +: 8] = data;
        req_dly[i*2 +: 2]  = dly;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) step();
    endtask

    initial begin
        // Reset held for two observed cycles with everyone requesting.
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i), 2'd3);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_valid", 32'(out_valid), 32'd0);
            step();
        end

        // Release: all four with delay 3, each dropping after its grant.
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req = (c < 4) ? 4'(4'hF << c) : 4'd0;
            @(negedge clk);
            if (c < 4) check("rr_gnt", 32'(gnt), 32'(1 << c));
            if (c >= 4) begin
                check("rr_valid", 32'(out_valid), 32'd1);
                check("rr_id", 32'(out_id), 32'(c - 4));
                check("rr_data", 32'(out_data), 32'(8'h10 + c - 4));
            end
            step();
        end
        idle(3);

        // Single request: requester 2, A5, delay 2.
        for (int c = 0; c < 6; c++) begin
            req = '0;
            if (c == 0) set_req(2, 8'hA5, 2'd2);
            @(negedge clk);
            if (c == 0) check("single_gnt", 32'(gnt), 32'h4);
            check("single_valid", 32'(out_valid), 32'(c == 3));
            if (c == 3) begin
                check("single_data", 32'(out_data), 32'hA5);
                check("single_id", 32'(out_id), 32'd2);
            end
            step();
        end

        // Fresh reset so the counters start from zero for the conflict case.
        req   = '0;
        reset = 1'b0;
        step();
        reset = 1'b1;

        // Slot conflict: req1 (delay 0) blocked by req0's item in s[1].
        for (int c = 0; c < 6; c++) begin
            req = '0;
            if (c == 0) set_req(0, 8'h01, 2'd1);
            if (c == 1) begin
                set_req(1, 8'h22, 2'd0);
                set_req(2, 8'h33, 2'd2);
            end
            if (c == 2) set_req(1, 8'h22, 2'd0);
            @(negedge clk);
            if (c == 0) check("conf_gnt0", 32'(gnt), 32'h1);
            if (c == 1) check("conf_gnt1", 32'(gnt), 32'h4);
            if (c == 2) check("conf_gnt2", 32'(gnt), 32'h2);
            check("conf_valid", 32'(out_valid), 32'(c >= 2 && c <= 4));
            if (c == 2) check("conf_id_t2", 32'(out_id), 32'd0);
            if (c == 3) check("conf_id_t3", 32'(out_id), 32'd1);
            if (c == 4) check("conf_id_t4", 32'(out_id), 32'd2);
            step();
        end
`ifdef DLA_STATS_EN
        check("stat_grants_lit", 32'(stat_grants), 32'd3);
        check("stat_conflicts_lit", 32'(stat_conflicts), 32'd0);
`endif

        // Requester 1 alone, blocked for two cycles by items in s[1].
        for (int c = 0; c < 5; c++) begin
            req = '0;
            if (c == 0) set_req(0, 8'h44, 2'd3);
            if (c == 1) set_req(0, 8'h55, 2'd1);
            if (c >= 2) set_req(1, 8'h66, 2'd0);
            @(negedge clk);
            if (c == 2 || c == 3) check("blk_gnt", 32'(gnt), 32'd0);
            if (c == 4) check("blk_gnt_late", 32'(gnt), 32'h2);
            step();
        end
        idle(3);
`ifdef DLA_STATS_EN
        check("stat_conflicts_blk", 32'(stat_conflicts), 32'd2);
        check("stat_grants_blk", 32'(stat_grants), 32'd6);
`endif

        // Reset one cycle after a delay-3 grant discards the item.
        for (int c = 0; c < 7; c++) begin
            req   = '0;
            reset = (c != 1);
            if (c == 0) set_req(3, 8'h77, 2'd3);
            @(negedge clk);
            if (c == 0) check("rstfly_gnt", 32'(gnt), 32'h8);
            if (c >= 2) check("rstfly_valid", 32'(out_valid), 32'd0);
            step();
        end

        // Randomized traffic obeying the hold-until-grant protocol.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!reset) begin
                    req[i] = 1'b0;
                end else if (mdl_gnt[i] || !req[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 8'($urandom), 2'($urandom_range(0, 3)));
                    else
                        req[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end
        reset = 1'b1;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_line_arbiter.md
Name: delay_line_arbiter

Overview:
- Shares one variable-tap 8-bit delay line (tap 0..3) among NREQ requesters.
- Each request carries a data byte and a requested delay. The block grants at most one request per cycle and inserts the byte into a slot pipeline so it emerges at exactly the requested latency.
- The block reserves output slots so that two items never exit in the same cycle.
- Sits between requester ports and the downstream single-consumer sink.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width in bits.
- DEPTH, 3, maximum delay value; the slot pipeline has DEPTH+1 entries.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk only.
- req  in  NREQ  per-requester request level.
- req_data  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_dly  in  NREQ*2  requester i delay in bits [i*2 +: 2]; value range 0..DEPTH.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as acceptance.
- out_valid  out  1  registered; item present this cycle.
- out_data  out  WIDTH  registered data of the exiting item.
- out_id  out  3  registered index of the requester that issued the exiting item.

Behaviour:
- Storage: slots s[0..DEPTH], each holding {valid, id, data}. The outputs are driven directly by s[0].
- Reset (reset==0 at posedge):
  - All slot valid bits clear; id and data clear to 0.
  - Round-robin pointer set to 0.
  - out_valid=0, out_data=0, out_id=0.
  - gnt is forced to 0 in any cycle where reset==0.
  - In-flight items are discarded, with no partial output.
- Shift, every posedge when not in reset:
  - s[i] <= s[i+1] for i<DEPTH.
  - s[DEPTH] <= empty.
- Eligibility: requester i with delay d is eligible if req[i]==1 and either d==DEPTH, or s[d+1].valid==0. This check confirms that the slot it will land in is free after the shift.
- Arbitration:
  - Round-robin among eligible requesters, starting the search at the pointer.
  - At most one gnt bit is high per cycle.
  - Ineligible requesters are skipped; they do not block others.
  - On a grant to requester k, the pointer becomes (k+1) mod NREQ. With no grant, the pointer holds.
- Insertion: the granted item is written into s[d] at the same edge as the shift. The write has priority over the shifted-in value, which the eligibility check guarantees is empty.
- Latency: an item accepted in cycle T appears with out_valid=1 in cycle T+d+1, for exactly one cycle.
- Ordering: output order follows exit slots, not acceptance order. A later request with a smaller delay may exit first.
- Requester protocol:
  - Hold req, req_data and req_dly stable until the gnt cycle.
  - Deassert req, or present a new request, on the cycle after gnt.
  - Dropping req before gnt is legal; no state is kept.
- req_dly > DEPTH cannot occur with the default DEPTH=3. For a smaller DEPTH, the value is clamped to DEPTH.
- The output has no backpressure; the sink must accept every out_valid cycle.
- Simultaneous events: a slot exits via s[0] in the same edge that a new item enters s[0] (d=0) only if s[1] was empty. No collision is possible.

Optional Feature:
- Macro: DLA_STATS_EN.
- When defined:
  - Adds output ports stat_grants[15:0] and stat_conflicts[15:0].
  - stat_grants counts cycles with any gnt bit high.
  - stat_conflicts counts cycles where |req==1 but no grant was possible because every requesting port was ineligible.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held low for 2 cycles with req=4'b1111 -> gnt=0 throughout; out_valid=0; after release the first grant goes to requester 0.
- Single request: req[2]=1, data 8'hA5, dly=2, accepted at T -> gnt=4'b0100 at T; out_valid=1, out_data=8'hA5, out_id=2 at T+3 only.
- All four requesting, each with dly=3 -> grants in order 0,1,2,3 on consecutive cycles; outputs appear on 4 consecutive cycles, ids 0,1,2,3.
- Slot conflict:
  - Requester 0 granted with dly=1 at T.
  - At T+1, requester 1 asks dly=0 (its slot is occupied by requester 0's item) while requester 2 asks dly=2.
  - Required: requester 2 granted at T+1; requester 1 granted at T+2.
  - Exits: id0 at T+2, id2 at T+4, id1 at T+3.
- Reset asserted 1 cycle after a dly=3 grant -> no out_valid for that item; slots empty after release.
- DLA_STATS_EN build, previous conflict scenario -> stat_grants=3; stat_conflicts=0. Forcing req[1] alone with a blocked slot for 2 cycles -> stat_conflicts=2.
